// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch slice: word/opcode types, the HALT opcode
// and the fetch FSM state enum.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    localparam opcode_t OP_HALT = 6'b111111;

    typedef enum logic {
        RUN,
        HALTED
    } fetch_state_t;

    // Primary opcode field of an instruction word.
    function automatic opcode_t opcode_of(input word_t w);
        return w[31:26];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer (instr, npc) holding a word returned while decode
// is stalled. Only instantiated when FETCH_SKID_EN is defined.
module fetch_skid_buf
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  clear,
    input  word_t load_instr,
    input  word_t load_npc,
    output logic  full,
    output word_t instr,
    output word_t npc
);

    // Capture on load, empty on clear (drain or redirect); clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            instr <= '0;
            npc   <= '0;
        end else if (clear) begin
            full  <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= load_instr;
            npc   <= load_npc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and
// fills the IF/ID latch. Edge priority is RST > redirect > stall > ihit.
// Optional macro FETCH_SKID_EN adds a one-entry skid buffer so a word
// returned during a stall is kept instead of refetched.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t   PC_INIT = 32'h0000_0000,
    parameter opcode_t HALT_OP = OP_HALT
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] pc_out,
    input  logic        redirect,
    input  logic [31:0] new_pc,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        halt_out
);

    fetch_state_t state, state_n;
    word_t        pc, pc_n, pc_inc;
    word_t        instr_n, npc_n;
    logic         valid_n;
    logic         is_halt;

`ifdef FETCH_SKID_EN
    logic  skid_full, skid_load, skid_clear;
    word_t skid_instr, skid_npc;

    fetch_skid_buf u_skid (
        .clk        (CLK),
        .rst        (RST),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_instr (iload),
        .load_npc   (pc_inc),
        .full       (skid_full),
        .instr      (skid_instr),
        .npc        (skid_npc)
    );

    assign iREN = (state == RUN) && !skid_full;
`else
    assign iREN = (state == RUN);
`endif

    assign pc_inc   = pc + 32'd4;
    assign is_halt  = (opcode_of(iload) == HALT_OP);
    assign pc_out   = pc;
    assign iaddr    = pc;
    assign halt_out = (state == HALTED);

    // State, PC and IF/ID latch registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            pc         <= PC_INIT;
            ifid_instr <= '0;
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            ifid_instr <= instr_n;
            ifid_npc   <= npc_n;
            ifid_valid <= valid_n;
        end
    end

    // Next-state, PC and IF/ID selection in redirect > stall > ihit order.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = ifid_instr;
        npc_n   = ifid_npc;
        valid_n = ifid_valid;
`ifdef FETCH_SKID_EN
        skid_load  = 1'b0;
        skid_clear = 1'b0;
`endif
        if (redirect) begin
            pc_n    = {new_pc[31:2], 2'b00};
            valid_n = 1'b0;
            state_n = RUN;
`ifdef FETCH_SKID_EN
            skid_clear = 1'b1;
`endif
        end else if (stall) begin
            // IF/ID holds; without the buffer an ihit here is simply dropped.
`ifdef FETCH_SKID_EN
            if (iREN && ihit) begin
                skid_load = 1'b1;
                if (is_halt) state_n = HALTED;
                else         pc_n    = pc_inc;
            end
`endif
        end
`ifdef FETCH_SKID_EN
        // A buffered word drains ahead of any new fetch (iREN is low meanwhile).
        else if (skid_full) begin
            instr_n    = skid_instr;
            npc_n      = skid_npc;
            valid_n    = 1'b1;
            skid_clear = 1'b1;
        end
`endif
        else if ((state == RUN) && ihit) begin
            instr_n = iload;
            npc_n   = pc_inc;
            valid_n = 1'b1;
            if (is_halt) state_n = HALTED;
            else         pc_n    = pc_inc;
        end else begin
            valid_n = 1'b0;
        end
    end

endmodule
